switch_debounce_ctrl: RTL
=========================

// Module: switch_debounce_ctrl
// PURPOSE
//  - Input-conditioning stage directly upstream of the LED blink driver.
//  - Takes the raw board rate-select switches and the enable push-button.
//  - Synchronises, debounces and registers them.
//  - Outputs are clean, glitch-free i_switch_1 / i_switch_2 / i_enable levels for the blink block.
//  - The enable button is converted to a toggle: each debounced press flips o_enable.
// PARAMETERS
//  - DEBOUNCE_CYCLES  250000  stable-input cycles required before an output changes (10 ms at 25 MHz); legal >= 2
//  - SYNC_STAGES      2       metastability synchroniser depth per raw input; legal >= 2
// PORTS
//  - i_clock            in   1  system clock (25 MHz board clock)
//  - i_reset_n          in   1  asynchronous, active-low reset
//  - i_sw_1_raw         in   1  raw rate-select switch 1, asynchronous to i_clock
//  - i_sw_2_raw         in   1  raw rate-select switch 2, asynchronous to i_clock
//  - i_enable_btn_raw   in   1  raw enable push-button, active-high, asynchronous
//  - o_switch_1         out  1  debounced switch 1 level
//  - o_switch_2         out  1  debounced switch 2 level
//  - o_enable           out  1  enable toggle state
//  - o_sel_change       out  1  1-cycle pulse on debounced rate-select change (macro-gated)
// BEHAVIOUR
//  - Reset: async assert when i_reset_n=0. All sync flops, debounce counters, stable states and outputs go to 0.
//    Release is sampled on the next i_clock rising edge.
//  - Per channel (3 instances):
//    - Raw input passes a SYNC_STAGES flop chain, giving s.
//    - Counter cnt, width $clog2(DEBOUNCE_CYCLES).
//    - If s == stable: cnt <= 0.
//    - Else if cnt == DEBOUNCE_CYCLES-1: stable <= s, cnt <= 0.
//    - Else: cnt <= cnt+1.
//  - Latency: a raw edge held steady reaches the output exactly SYNC_STAGES+DEBOUNCE_CYCLES cycles later.
//  - Glitch rejection: any bounce back to the stable value before cnt reaches terminal clears cnt. No output change.
//  - Counter never wraps: it saturates at terminal and is cleared in the same cycle stable updates.
//  - o_switch_1/o_switch_2 are the registered stable states of channels 1/2.
//  - Enable FSM, 2 states:
//    - IDLE -> PRESSED on debounced button rising edge: o_enable <= ~o_enable.
//    - PRESSED -> IDLE on debounced falling edge. No action.
//    - Holding the button never re-toggles.
//  - Simultaneous events:
//    - Channels are independent. Switches and button may resolve in the same cycle; each output updates on its own.
//    - Both switches resolving in one cycle yields a single o_sel_change pulse.
//  - Reset mid-debounce discards partial counts. Outputs return to 0 and o_enable returns to 0.
// CONFIGURATION
//  - Macro SWITCH_DEBOUNCE_SEL_CHANGE_PULSE_EN.
//  - Defined: o_sel_change = 1 for exactly one cycle, in the same cycle {o_switch_1,o_switch_2} changes.
//    Registered; reset 0.
//  - Undefined: o_sel_change is tied 0 and its detect register is not built. Port list is unchanged.
// STRUCTURE
//  - Shared package/header led_ctrl_pkg holds:
//    - CLK_FREQ_HZ = 25_000_000.
//    - DEFAULT_DEBOUNCE_CYCLES.
//    - Rate-select encoding constants SEL_100HZ=2'b00, SEL_50HZ=2'b01, SEL_10HZ=2'b10, SEL_1HZ=2'b11.
//      {o_switch_1,o_switch_2} follows this encoding.
//  - One sub-module debounce_channel (synchroniser + counter + stable flop), instantiated 3 times.
//  - Top keeps only the enable FSM and the change-pulse logic.
// TESTING
//  - Use DEBOUNCE_CYCLES=8, SYNC_STAGES=2.
//  - Assert i_reset_n=0 with raw inputs all 1 -> all outputs 0 during reset; they stay 0 until 2+8 cycles after release.
//  - i_sw_1_raw 0->1 held -> o_switch_1=1 exactly 10 cycles after the edge; o_sel_change pulses once (macro on).
//  - i_sw_2_raw toggles 1 for 5 cycles then 0 -> o_switch_2 stays 0, no o_sel_change.
//  - Button press held 50 cycles, release, press again -> o_enable 0->1 after the first press, 1->0 after the second.
//    No toggle on release.
//  - Both raw switches 00->11 in the same cycle -> both outputs change in the same cycle; exactly one o_sel_change pulse.
//  - i_reset_n=0 at cnt=5 of a pending change, then release -> output stays 0; the full 10-cycle delay restarts.
//  - Macro undefined: rerun the switch-1 scenario -> o_sel_change constantly 0, other outputs identical.

Source files
------------

// File: rtl/led_ctrl_pkg.sv
// Shared constants for the LED blink path: board clock, debounce defaults,
// rate-select encoding of {o_switch_1,o_switch_2} and the enable FSM states.
package led_ctrl_pkg;

  localparam int unsigned CLK_FREQ_HZ             = 25_000_000;
  // 10 ms of stable input at the board clock.
  localparam int unsigned DEFAULT_DEBOUNCE_CYCLES = CLK_FREQ_HZ / 100;
  localparam int unsigned DEFAULT_SYNC_STAGES     = 2;

  typedef logic [1:0] rate_sel_t;

  localparam rate_sel_t SEL_100HZ = 2'b00;
  localparam rate_sel_t SEL_50HZ  = 2'b01;
  localparam rate_sel_t SEL_10HZ  = 2'b10;
  localparam rate_sel_t SEL_1HZ   = 2'b11;

  typedef enum logic {
    EN_IDLE    = 1'b0,
    EN_PRESSED = 1'b1
  } en_state_t;

endpackage

// File: rtl/switch_debounce_ctrl_if.sv
// Signal bundle for the raw board inputs and the conditioned levels handed
// to the blink driver; master drives the raw side, slave produces outputs.
interface switch_debounce_ctrl_if;

  logic sw_1_raw;
  logic sw_2_raw;
  logic enable_btn_raw;
  logic switch_1;
  logic switch_2;
  logic enable;
  logic sel_change;

  modport master (
    output sw_1_raw, sw_2_raw, enable_btn_raw,
    input  switch_1, switch_2, enable, sel_change
  );

  modport slave (
    input  sw_1_raw, sw_2_raw, enable_btn_raw,
    output switch_1, switch_2, enable, sel_change
  );

endinterface

// File: rtl/debounce_channel.sv
// One input channel: SYNC_STAGES synchroniser, saturating debounce counter
// and the registered stable level.
module debounce_channel
  import led_ctrl_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int unsigned SYNC_STAGES     = DEFAULT_SYNC_STAGES
) (
  input  logic i_clock,
  input  logic i_reset_n,
  input  logic i_raw,
  output logic o_stable,
  output logic o_changing
);

  localparam int unsigned       CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0]  TERM  = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync;
  logic [CNT_W-1:0]       cnt;
  logic                   stable;
  logic                   s;

  assign s        = sync[SYNC_STAGES-1];
  assign o_stable = stable;

  // High in the cycle before stable flips, so a downstream register can
  // pulse in the same cycle the stable level changes.
  always_comb begin
    o_changing = (s != stable) && (cnt == TERM);
  end

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      sync   <= '0;
      cnt    <= '0;
      stable <= 1'b0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], i_raw};
      if (s == stable) begin
        cnt <= '0;
      end else if (cnt == TERM) begin
        stable <= s;
        cnt    <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/switch_debounce_ctrl.sv
// Conditions the rate-select switches and enable button for the blink driver.
// Optional o_sel_change pulse built only with SWITCH_DEBOUNCE_SEL_CHANGE_PULSE_EN.
module switch_debounce_ctrl
  import led_ctrl_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int unsigned SYNC_STAGES     = DEFAULT_SYNC_STAGES
) (
  input  logic i_clock,
  input  logic i_reset_n,
  input  logic i_sw_1_raw,
  input  logic i_sw_2_raw,
  input  logic i_enable_btn_raw,
  output logic o_switch_1,
  output logic o_switch_2,
  output logic o_enable,
  output logic o_sel_change
);

  logic      btn_stable;
  logic      sw_1_chg;
  logic      sw_2_chg;
  logic      unused_btn_chg;
  en_state_t state;

  debounce_channel #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .SYNC_STAGES(SYNC_STAGES)) u_sw_1 (
    .i_clock    (i_clock),
    .i_reset_n  (i_reset_n),
    .i_raw      (i_sw_1_raw),
    .o_stable   (o_switch_1),
    .o_changing (sw_1_chg)
  );

  debounce_channel #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .SYNC_STAGES(SYNC_STAGES)) u_sw_2 (
    .i_clock    (i_clock),
    .i_reset_n  (i_reset_n),
    .i_raw      (i_sw_2_raw),
    .o_stable   (o_switch_2),
    .o_changing (sw_2_chg)
  );

  debounce_channel #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .SYNC_STAGES(SYNC_STAGES)) u_btn (
    .i_clock    (i_clock),
    .i_reset_n  (i_reset_n),
    .i_raw      (i_enable_btn_raw),
    .o_stable   (btn_stable),
    .o_changing (unused_btn_chg)
  );

  // Toggle on each debounced press; holding or releasing never toggles.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state    <= EN_IDLE;
      o_enable <= 1'b0;
    end else begin
      case (state)
        EN_IDLE: begin
          if (btn_stable) begin
            state    <= EN_PRESSED;
            o_enable <= ~o_enable;
          end
        end
        EN_PRESSED: begin
          if (!btn_stable) begin
            state <= EN_IDLE;
          end
        end
        default: state <= EN_IDLE;
      endcase
    end
  end

`ifdef SWITCH_DEBOUNCE_SEL_CHANGE_PULSE_EN
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      o_sel_change <= 1'b0;
    end else begin
      o_sel_change <= sw_1_chg | sw_2_chg;
    end
  end
`else
  logic unused_sel_chg;
  assign unused_sel_chg = sw_1_chg | sw_2_chg;
  assign o_sel_change   = 1'b0;
`endif

endmodule
